tdm_deserializer: RTL and testbench

Parametrised bit-serial to word-parallel receiver for the FIR datapath input. It generalises the fixed 24-bit single-channel deserializer to configurable word width, bit order and time-division-multiplexed channel count. It adds frame synchronisation, downstream backpressure and an optional per-word parity check. It sits between the serial input pins and the FIR sample input (`fir_din`) in `top_level`.

---
 rtl/tdm_deserializer_if.sv | 29 ++
 rtl/tdm_deserializer.sv | 177 +++++++++++++++++
 tb/tb_tdm_deserializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_deserializer_if.sv
// Bus bundle for tdm_deserializer: serial bit input side and word output handshake.
// master = deserializer side, slave = environment side.
interface tdm_deserializer_if #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
);
  logic                  i_din;
  logic                  i_din_valid;
  logic                  i_frame_sync;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_dout;
  logic [CH_W-1:0]       o_chan;
  logic                  o_frame_last;
  logic                  o_dout_valid;
  logic                  i_ready;
  logic                  o_par_err;
  logic                  o_sync_err;

  modport master (
    input  i_din, i_din_valid, i_frame_sync, i_ready,
    output o_ready, o_dout, o_chan, o_frame_last, o_dout_valid, o_par_err, o_sync_err
  );

  modport slave (
    output i_din, i_din_valid, i_frame_sync, i_ready,
    input  o_ready, o_dout, o_chan, o_frame_last, o_dout_valid, o_par_err, o_sync_err
  );
endinterface

// File: rtl/tdm_deserializer.sv
// Bit-serial to word-parallel TDM receiver with frame sync, one pending word of buffering
// and backpressure. Define DESER_PARITY_EN for a trailing even-parity bit per word.
module tdm_deserializer #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input logic i_clk,
  input logic i_rst,
  input logic i_en,
  tdm_deserializer_if.master bus
);
`ifdef DESER_PARITY_EN
  localparam int unsigned WORD_BITS = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_BITS = DATA_WIDTH;
`endif
  localparam int unsigned BIT_W = $clog2(WORD_BITS + 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d, bit_base;
  logic [CH_W-1:0]       chan_cnt_q, chan_cnt_d, chan_base;
  logic [CH_W-1:0]       pend_chan_q, pend_chan_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [CH_W-1:0]       chan_q, chan_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  accept, out_free, sync, word_done;
`ifdef DESER_PARITY_EN
  logic                  par_acc_q, par_acc_d, par_base;
  logic                  pend_par_q, pend_par_d;
  logic                  par_err_q, par_err_d;
  logic                  word_perr;
`endif

  assign bus.o_ready = i_en & ~i_rst & ~pending_q;
  assign accept      = i_en & bus.i_din_valid & bus.o_ready;
  assign sync        = i_en & bus.i_frame_sync;
  assign out_free    = ~valid_q | bus.i_ready;

  // Next-state: sync first, then bit accept, then output register transfer.
  always_comb begin
    shreg_d     = shreg_q;
    pend_chan_d = pend_chan_q;
    pending_d   = pending_q;
    dout_d      = dout_q;
    chan_d      = chan_q;
    last_d      = last_q;
    valid_d     = valid_q;
    sync_err_d  = 1'b0;
    word_done   = 1'b0;
    bit_base    = bit_cnt_q;
    chan_base   = chan_cnt_q;
`ifdef DESER_PARITY_EN
    par_base    = par_acc_q;
    pend_par_d  = pend_par_q;
    par_err_d   = par_err_q;
    word_perr   = 1'b0;
`endif

    if (sync) begin
      bit_base   = '0;
      chan_base  = '0;
      sync_err_d = (bit_cnt_q != '0);
`ifdef DESER_PARITY_EN
      par_base   = 1'b0;
`endif
    end

    bit_cnt_d  = bit_base;
    chan_cnt_d = chan_base;
`ifdef DESER_PARITY_EN
    par_acc_d  = par_base;
`endif

    if (accept) begin
      if (bit_base < BIT_W'(DATA_WIDTH)) begin
        if (LSB_FIRST != 0) shreg_d = {bus.i_din, shreg_q[DATA_WIDTH-1:1]};
        else                shreg_d = {shreg_q[DATA_WIDTH-2:0], bus.i_din};
`ifdef DESER_PARITY_EN
        par_acc_d = par_base ^ bus.i_din;
`endif
      end
      if (bit_base == BIT_W'(WORD_BITS - 1)) begin
        word_done  = 1'b1;
        bit_cnt_d  = '0;
        chan_cnt_d = (chan_base == CH_W'(NUM_CHANNELS - 1)) ? '0 : chan_base + 1'b1;
`ifdef DESER_PARITY_EN
        par_acc_d  = 1'b0;
        word_perr  = par_base ^ bus.i_din;
`endif
      end else begin
        bit_cnt_d = bit_base + 1'b1;
      end
    end

    // A pending word excludes accepts, so it never collides with word_done.
    if (pending_q && out_free) begin
      dout_d    = shreg_q;
      chan_d    = pend_chan_q;
      last_d    = (pend_chan_q == CH_W'(NUM_CHANNELS - 1));
      valid_d   = 1'b1;
      pending_d = 1'b0;
`ifdef DESER_PARITY_EN
      par_err_d = pend_par_q;
`endif
    end else if (word_done) begin
      if (out_free) begin
        dout_d    = shreg_d;
        chan_d    = chan_base;
        last_d    = (chan_base == CH_W'(NUM_CHANNELS - 1));
        valid_d   = 1'b1;
`ifdef DESER_PARITY_EN
        par_err_d = word_perr;
`endif
      end else begin
        pending_d   = 1'b1;
        pend_chan_d = chan_base;
`ifdef DESER_PARITY_EN
        pend_par_d  = word_perr;
`endif
      end
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      chan_cnt_q  <= '0;
      pend_chan_q <= '0;
      pending_q   <= 1'b0;
      dout_q      <= '0;
      chan_q      <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      sync_err_q  <= 1'b0;
`ifdef DESER_PARITY_EN
      par_acc_q   <= 1'b0;
      pend_par_q  <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_cnt_q  <= chan_cnt_d;
      pend_chan_q <= pend_chan_d;
      pending_q   <= pending_d;
      dout_q      <= dout_d;
      chan_q      <= chan_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      sync_err_q  <= sync_err_d;
`ifdef DESER_PARITY_EN
      par_acc_q   <= par_acc_d;
      pend_par_q  <= pend_par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.o_dout       = dout_q;
  assign bus.o_chan       = chan_q;
  assign bus.o_frame_last = last_q;
  assign bus.o_dout_valid = valid_q;
  assign bus.o_sync_err   = sync_err_q;
`ifdef DESER_PARITY_EN
  assign bus.o_par_err    = par_err_q;
`else
  assign bus.o_par_err    = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_deserializer.sv
// Self-checking bench for tdm_deserializer: directed steps plus randomized words,
// checked against a bit-level reference model and an expected-word queue.
module tb_tdm_deserializer;
  localparam int unsigned DW   = 24;
  localparam int unsigned NCH  = 2;
  localparam int unsigned LSB  = 1;
`ifdef DESER_PARITY_EN
  localparam int unsigned WB   = DW + 1;
`else
  localparam int unsigned WB   = DW;
`endif

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   ch;
    logic          last;
    logic          perr;
  } exp_t;

  logic clk, rst, en;
  int   checks, failures, stalls;
  bit   rnd, mon_en;
  exp_t q[$];
  exp_t e;
  bit   m_bits[WB];
  int unsigned m_cnt, m_chan;

  tdm_deserializer_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();

  tdm_deserializer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .LSB_FIRST(LSB)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: collect accepted bits, form a word once WB bits arrived.
  task automatic model_accept(input bit b);
    logic [DW-1:0] d;
    logic p;
    m_bits[m_cnt] = b;
    m_cnt++;
    if (m_cnt == WB) begin
      d = '0;
      for (int i = 0; i < int'(DW); i++) begin
        if (LSB != 0) d[i] = m_bits[i];
        else          d[DW-1-i] = m_bits[i];
      end
`ifdef DESER_PARITY_EN
      p = ((^d) != m_bits[DW]);
`else
      p = 1'b0;
`endif
      q.push_back('{d: d, ch: m_chan, last: (m_chan == NCH - 1), perr: p});
      m_chan = (m_chan + 1) % NCH;
      m_cnt  = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the bit.
  task automatic send_bit(input bit b);
    logic acc;
    bus.i_din       = b;
    bus.i_din_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (rnd) begin
        en          = ($urandom % 4) != 0;
        bus.i_ready = 1'($urandom % 2);
      end
      @(negedge clk);
      acc = bus.o_ready & en;
      step();
      if (acc) begin
        model_accept(b);
        return;
      end
      stalls++;
    end
    check("send_bit_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [DW-1:0] data, input bit flip);
    bit b;
    for (int i = 0; i < int'(WB); i++) begin
      if (i < int'(DW)) b = (LSB != 0) ? data[i] : data[DW-1-i];
      else              b = (^data) ^ flip;
      if (rnd) begin
        bus.i_din_valid = 1'b0;
        repeat ($urandom % 3) step();
      end
      send_bit(b);
    end
  endtask

  task automatic idle(input int n);
    bus.i_din_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_sync(input bit exp_err);
    bus.i_frame_sync = 1'b1;
    bus.i_din_valid  = 1'b0;
    m_cnt  = 0;
    m_chan = 0;
    step();
    bus.i_frame_sync = 1'b0;
    @(negedge clk);
    check("sync_err_pulse", 64'(bus.o_sync_err), 64'(exp_err));
    step();
    @(negedge clk);
    check("sync_err_end", 64'(bus.o_sync_err), 64'd0);
    step();
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_ready", 64'(bus.o_ready), 64'(exp_ready));
    check("rst_valid", 64'(bus.o_dout_valid), 64'd0);
    check("rst_dout", 64'(bus.o_dout), 64'd0);
    check("rst_chan", 64'(bus.o_chan), 64'd0);
    check("rst_last", 64'(bus.o_frame_last), 64'd0);
    check("rst_par_err", 64'(bus.o_par_err), 64'd0);
    check("rst_sync_err", 64'(bus.o_sync_err), 64'd0);
  endtask

  // Output monitor: every handshake must match the next expected word.
  always @(negedge clk) begin
    if (mon_en && !rst && bus.o_dout_valid && bus.i_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", 64'(bus.o_dout), 64'hDEAD);
      end else begin
        e = q.pop_front();
        check("word_data", 64'(bus.o_dout), 64'(e.d));
        check("word_chan", 64'(bus.o_chan), 64'(e.ch));
        check("word_last", 64'(bus.o_frame_last), 64'(e.last));
        check("word_par_err", 64'(bus.o_par_err), 64'(e.perr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w1, w2;
    checks = 0; failures = 0; stalls = 0;
    rnd = 0; mon_en = 0; m_cnt = 0; m_chan = 0;
    rst = 1'b1; en = 1'b1;
    bus.i_din = 1'b0; bus.i_din_valid = 1'b0; bus.i_frame_sync = 1'b0; bus.i_ready = 1'b1;

    // Reset values and ready behaviour around reset.
    repeat (2) step();
    @(negedge clk);
    check_reset_outputs(1'b0);
    step();
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.o_ready), 64'd1);
    step();

    // Single word: latency and one-cycle valid.
    send_word(24'hA5C3F0, 1'b0);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("first_valid", 64'(bus.o_dout_valid), 64'd1);
    check("first_dout", 64'(bus.o_dout), 64'hA5C3F0);
    check("first_chan", 64'(bus.o_chan), 64'd0);
    step();
    @(negedge clk);
    check("first_valid_drop", 64'(bus.o_dout_valid), 64'd0);
    step();

    // Four back-to-back words from a clean frame start: no stalls.
    do_sync(1'b0);
    stalls = 0;
    for (int i = 0; i < 4; i++) send_word(DW'($urandom), 1'b0);
    idle(3);
    check("b2b_stalls", 64'(stalls), 64'd0);
    check("b2b_drained", 64'(q.size()), 64'd0);

    // Backpressure: second word goes pending and blocks acceptance.
    w1 = DW'($urandom);
    w2 = DW'($urandom);
    bus.i_ready = 1'b0;
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("bp_ready_low", 64'(bus.o_ready), 64'd0);
    repeat (10) step();
    @(negedge clk);
    check("bp_ready_held", 64'(bus.o_ready), 64'd0);
    check("bp_valid_held", 64'(bus.o_dout_valid), 64'd1);
    check("bp_dout_held", 64'(bus.o_dout), 64'(w1));
    step();
    bus.i_ready = 1'b1;
    idle(4);
    check("bp_drained", 64'(q.size()), 64'd0);
    @(negedge clk);
    check("bp_ready_back", 64'(bus.o_ready), 64'd1);
    step();

    // Sync mid-word: error pulse, partial word dropped, next word is channel 0.
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    do_sync(1'b1);
    send_word(24'h000001, 1'b0);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("sync_word_chan", 64'(bus.o_chan), 64'd0);
    check("sync_word_dout", 64'(bus.o_dout), 64'h000001);
    step();
    idle(2);

`ifdef DESER_PARITY_EN
    send_word(24'h000003, 1'b1);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("par_bad_dout", 64'(bus.o_dout), 64'h000003);
    check("par_bad_err", 64'(bus.o_par_err), 64'd1);
    step();
    send_word(24'h000003, 1'b0);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("par_ok_err", 64'(bus.o_par_err), 64'd0);
    step();
    idle(2);
`endif

    // Reset mid-word: everything discarded.
    for (int i = 0; i < 12; i++) send_bit(1'($urandom));
    bus.i_din_valid = 1'b0;
    rst = 1'b1;
    m_cnt = 0; m_chan = 0;
    q.delete();
    @(negedge clk);
    check("midrst_ready", 64'(bus.o_ready), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b1);
    step();
    w1 = DW'($urandom);
    send_word(w1, 1'b0);
    bus.i_din_valid = 1'b0;
    @(negedge clk);
    check("postrst_valid", 64'(bus.o_dout_valid), 64'd1);
    check("postrst_dout", 64'(bus.o_dout), 64'(w1));
    check("postrst_chan", 64'(bus.o_chan), 64'd0);
    step();
    idle(2);

    // Randomized: valid gaps, enable toggling and random downstream ready.
    rnd = 1;
    for (int i = 0; i < 30; i++) send_word(DW'($urandom), 1'($urandom % 2));
    rnd = 0;
    en = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_din_valid = 1'b0;
    for (int k = 0; k < 50 && q.size() != 0; k++) step();
    check("final_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
